hsem_ahb_mst: RTL

//  AHB initiator for the hardware-semaphore subsystem; the master counterpart of the semaphore AHB slave interface.

---
 rtl/hsem_ahb_mst_pkg.sv | 29 ++
 rtl/hsem_ahb_mst.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/hsem_ahb_mst_pkg.sv
// Shared AHB encodings and FSM state type for the semaphore AHB initiator.
// Also carries the subsystem-wide width macros used as parameter defaults.
`ifndef HSEM_DEFINES_SV
`define HSEM_DEFINES_SV
`define AHB_DATA_WIDTH     32
`define AHB_SEM_ADDR_WIDTH 32
`endif

package hsem_ahb_mst_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;
    localparam logic [1:0] HRESP_RETRY = 2'b10;
    localparam logic [1:0] HRESP_SPLIT = 2'b11;

    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_ERR2 = 2'd3
    } mst_state_e;

endpackage

// File: rtl/hsem_ahb_mst.sv
// AHB initiator for the hardware-semaphore subsystem.
// Single-word commands become single NONSEQ transfers, one outstanding at a time.
// Optional feature macro: HSEM_MST_RETRY_EN -- re-issue the same command up to
// MAX_RETRY times after a two-cycle non-OKAY response before reporting an error.
module hsem_ahb_mst
    import hsem_ahb_mst_pkg::*;
#(
    parameter int         ADDR_W    = `AHB_SEM_ADDR_WIDTH,
    parameter int         DATA_W    = `AHB_DATA_WIDTH,
    parameter int         MAX_RETRY = 3,
    parameter logic [3:0] HPROT_VAL = 4'b0011
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] haddr,
    output logic [1:0]        htrans,
    output logic              hwrite,
    output logic [2:0]        hsize,
    output logic [2:0]        hburst,
    output logic [3:0]        hprot,
    output logic              hmastlock,
    output logic [DATA_W-1:0] hwdata,
    input  logic              hready,
    input  logic [1:0]        hresp,
    input  logic [DATA_W-1:0] hrdata
);

    mst_state_e        state_q, state_d;
    logic [ADDR_W-1:0] haddr_q, haddr_d;
    logic              hwrite_q, hwrite_d;
    logic [DATA_W-1:0] hwdata_q, hwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    // Byte-lane bits of the command address never reach the bus.
    logic [1:0] unused_addr_lsb;
    assign unused_addr_lsb = cmd_addr[1:0];

`ifdef HSEM_MST_RETRY_EN
    localparam int             RC_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RC_W-1:0] RC_MAX = RC_W'(MAX_RETRY);
    logic [RC_W-1:0] retry_cnt_q, retry_cnt_d;

    // Retry attempts used by the command currently in flight.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) retry_cnt_q <= '0;
        else          retry_cnt_q <= retry_cnt_d;
    end
`endif

    // Command/bus state registers; reset abandons any transfer silently.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q     <= ST_IDLE;
            haddr_q     <= '0;
            hwrite_q    <= 1'b0;
            hwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            haddr_q     <= haddr_d;
            hwrite_q    <= hwrite_d;
            hwdata_q    <= hwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Next-state: accept command, address phase, data phase, two-cycle error tail.
    always_comb begin
        state_d     = state_q;
        haddr_d     = haddr_q;
        hwrite_d    = hwrite_q;
        hwdata_d    = hwdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        cmd_ready   = 1'b0;
`ifdef HSEM_MST_RETRY_EN
        retry_cnt_d = retry_cnt_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    haddr_d  = {cmd_addr[ADDR_W-1:2], 2'b00};
                    hwrite_d = cmd_write;
                    hwdata_d = cmd_wdata;
                    state_d  = ST_ADDR;
`ifdef HSEM_MST_RETRY_EN
                    retry_cnt_d = '0;
`endif
                end
            end
            ST_ADDR: begin
                if (hready) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (hready) begin
                    // Completion; a one-cycle non-OKAY is a slave protocol
                    // violation and is reported as a final error.
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = (hresp != HRESP_OKAY);
                    rsp_rdata_d = (hwrite_q || hresp != HRESP_OKAY) ? '0 : hrdata;
                end else if (hresp != HRESP_OKAY) begin
                    state_d = ST_ERR2;
                end
            end
            ST_ERR2: begin
                if (hready) begin
`ifdef HSEM_MST_RETRY_EN
                    if (retry_cnt_q < RC_MAX) begin
                        retry_cnt_d = retry_cnt_q + 1'b1;
                        state_d     = ST_ADDR;
                    end else begin
                        state_d     = ST_IDLE;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end
`else
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign htrans    = (state_q == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign haddr     = haddr_q;
    assign hwrite    = hwrite_q;
    assign hwdata    = hwdata_q;
    assign hsize     = HSIZE_WORD;
    assign hburst    = HBURST_SINGLE;
    assign hprot     = HPROT_VAL;
    assign hmastlock = 1'b0;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule
